// File: rtl/pipeline_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
// master: fetch side (drives imem_req/imem_addr); slave: memory side.
interface pipeline_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pipeline_fetch_unit.sv
// Fetch stage + IF/ID register: owns the PC, requests imem, feeds decode.
// Ports: clk/rst_n, hazard stalls, decode redirect, imem bus, IF/ID outputs.
module pipeline_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_fetch,
    input  logic                         stall_decode,
    input  logic                         pcsrc_decode,
    input  logic [31:0]                  branch_target_decode,
    pipeline_fetch_unit_if.master        imem,
    output logic [31:0]                  instr_decode,
    output logic [31:0]                  pc_plus4_decode,
    output logic                         valid_decode,
    output logic                         fetch_wait
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] hold_q;
    logic [31:0] hold_d;
    logic [31:0] tgt_q;
    logic [31:0] tgt_d;
    logic        pend_q;
    logic        pend_d;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic        offer_valid;
    logic [31:0] offer_instr;

    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;

    assign pc_plus4 = pc_q + 32'd4;
    // A redirect is only honoured once decode is free to consume it.
    assign redirect = pcsrc_decode & ~stall_decode;

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;
    assign fetch_wait     = (state_q == REQ) & ~imem.imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        offer_valid = 1'b0;
        offer_instr = imem.imem_rdata;

        unique case (state_q)
            REQ: begin
                if (!imem.imem_ready) begin
                    // Request cannot be withdrawn: remember where to go.
                    if (redirect) begin
                        pend_d = 1'b1;
                        tgt_d  = branch_target_decode;
                    end
                end else if (pend_q || redirect) begin
                    // Returned word is wrong-path; a fresh redirect
                    // supersedes the latched one.
                    pc_d   = redirect ? branch_target_decode : tgt_q;
                    pend_d = 1'b0;
                end else if (stall_fetch) begin
                    hold_d  = imem.imem_rdata;
                    state_d = HOLD;
                end else begin
                    offer_valid = 1'b1;
                    pc_d        = pc_plus4;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = branch_target_decode;
                    state_d = REQ;
                end else if (!stall_fetch) begin
                    offer_valid = 1'b1;
                    offer_instr = hold_q;
                    pc_d        = pc_plus4;
                    state_d     = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        instr_d = offer_valid ? offer_instr : 32'd0;
        pc4_d   = offer_valid ? pc_plus4 : 32'd0;
        valid_d = offer_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            hold_q <= 32'd0;
            tgt_q  <= 32'd0;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            hold_q <= hold_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_decode    <= 32'd0;
            pc_plus4_decode <= 32'd0;
            valid_decode    <= 1'b0;
        end else if (!stall_decode) begin
            instr_decode    <= instr_d;
            pc_plus4_decode <= pc4_d;
            valid_decode    <= valid_d;
        end
    end

endmodule

// File: doc/pipeline_fetch_unit.md
# pipeline_fetch_unit

Fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. Owns the program counter and drives a request/ready handshake to instruction memory. Presents the fetched instruction and PC+4 to the decode stage. Honours `stall_fetch`/`stall_decode` from the hazard unit and redirects on a taken branch or jump resolved in decode; the wrong-path instruction is flushed and there is no delay slot.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `stall_fetch` in 1: hazard unit; hold the PC.
- `stall_decode` in 1: hazard unit; hold the IF/ID register.
- `pcsrc_decode` in 1: taken branch or jump resolved in decode.
- `branch_target_decode` in 32: redirect target.
- `imem_req` out 1: instruction request.
- `imem_addr` out 32: request address. Equals the PC.
- `imem_ready` in 1: memory accepts the request and returns data this cycle.
- `imem_rdata` in 32: instruction. Valid only when `imem_ready`=1.
- `instr_decode` out 32: IF/ID instruction.
- `pc_plus4_decode` out 32: IF/ID PC+4.
- `valid_decode` out 1: IF/ID holds a real instruction.
- `fetch_wait` out 1: request outstanding and not ready this cycle.

## Operation
- **Reset values:**
  - PC = `RESET_PC`.
  - `instr_decode` = 0 (NOP), `pc_plus4_decode` = 0, `valid_decode` = 0.
  - State = REQ, `redirect_pending` = 0.
  - `imem_req` = 1 from the first cycle after `rst_n` deasserts.
- **State machine: REQ and HOLD.**
- **REQ state:**
  - `imem_req` = 1 and `imem_addr` = PC.
  - Address stays stable until a `imem_ready` edge; a request is never withdrawn.
- **REQ, ready=1, stall_fetch=0:**
  - IF/ID loads {`imem_rdata`, PC+4, valid=1}.
  - PC <= next_pc. Stay in REQ.
- **REQ, ready=1, stall_fetch=1:**
  - Capture `imem_rdata` into the hold buffer; go to HOLD. PC does not change.
  - IF/ID follows the `stall_decode` rule below.
- **REQ, ready=0:**
  - `fetch_wait` = 1.
  - If `stall_decode`=0, IF/ID loads a bubble {0, 0, valid=0}.
- **HOLD state:**
  - `imem_req` = 0 and `fetch_wait` = 0.
  - When `stall_fetch`=0: IF/ID loads {hold buffer, PC+4, valid=1}; PC <= next_pc; go to REQ.
- **IF/ID hold:** `stall_decode`=1 keeps the register unchanged and takes priority over every load and bubble.
- **next_pc:** PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0), unless a redirect applies.
- **Redirect:** applies when `pcsrc_decode`=1 and `stall_decode`=0. The fetch-side instruction is wrong-path.
  - **REQ with ready=1, or HOLD:** discard the data or hold buffer. IF/ID loads a bubble. PC <= `branch_target_decode`. State -> REQ.
  - **REQ with ready=0:** latch the target and set `redirect_pending`. IF/ID loads a bubble.
    - The request stays on the old address.
    - On the ready edge, discard the data, PC <= latched target, clear `redirect_pending`.
    - While `redirect_pending`=1, `valid_decode` never becomes 1 and `stall_fetch` is ignored.
  - A second redirect while one is pending overwrites the latched target.
- **Redirect vs stall_fetch:** the redirect wins over `stall_fetch` for the PC update.
- **Target alignment:** `branch_target_decode[1:0]` is not checked; the PC takes the value as given.

## Timing
- **Fetch latency:** 1 cycle from a ready edge to `instr_decode`. Zero-wait memory gives 1 instruction per cycle.
- **Redirect penalty:** exactly one bubble when no request is outstanding. One bubble plus the remaining wait cycles when a request is outstanding.
- **Comb paths:**
  - `fetch_wait` = (state==REQ) & ~`imem_ready`.
  - `imem_addr` and `imem_req` depend on registered state only.
- **Async reset:** assertion mid-request immediately drops IF/ID to NOP/invalid and the PC to `RESET_PC`. The outstanding request is abandoned, and memory must tolerate this.

## Test plan
- **Reset then zero-wait memory:** `rst_n` low to high, `RESET_PC`=0, ready=1 every cycle -> `imem_addr` 0, 4, 8; `pc_plus4_decode` 4, 8, 12 one cycle later; `valid_decode`=1 from cycle 2.
- **Load-use stall:** `stall_fetch`=`stall_decode`=1 for 2 cycles while fetching at 0x10 -> `imem_req`=0 in HOLD; IF/ID frozen on the 0x0C instruction. On release, 0x10's word (captured once) appears with `pc_plus4_decode`=0x14, and the next request is 0x14.
- **Taken branch:** `pcsrc_decode`=1, target 0x100, while 0x24 is being fetched (ready=1) -> 0x24 discarded; IF/ID bubble; next `imem_addr`=0x100; `valid_decode` returns with `pc_plus4_decode`=0x104.
- **Redirect during wait state:** ready=0 for 3 cycles at 0x40, `pcsrc_decode` pulse with target 0x200 -> `imem_addr` stays 0x40 until ready. Its data is dropped, then 0x200 is requested. `valid_decode`=0 throughout.
- **Wrap-around:** PC 0xFFFF_FFFC fetched -> `pc_plus4_decode`=0, next `imem_addr`=0.
- **Reset mid-request:** `rst_n` low while `fetch_wait`=1 -> outputs reach reset values without a clock edge; fetch restarts at `RESET_PC`.
